gray_cdc_receiver: RTL

Domain-B endpoint of the toggle request/acknowledge word-transfer protocol used on the 16-bit Gray counter path into the 7-segment display.
- Synchronizes an asynchronous toggle request from domain A.
- Captures the held data word and decodes Gray to binary.
- Checks that each word is a single-bit step from the previous one.
- Returns a toggle acknowledge so the sender may launch the next word.
- Feeds hex2seg/numbers_output with a clean, validated word.

---
 rtl/gray_cdc_receiver.sv | 124 ++++++++++++
 1 files changed

// File: rtl/gray_cdc_receiver.sv
// Domain-B receiver for toggle req/ack Gray word transfers.
// Define GRAY_CDC_STEP_CHECK_EN to enable the Gray single-step check.
module gray_cdc_receiver #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_req,
  input  logic [DATA_W-1:0]  a_data,
  output logic               b_ack,
  output logic               b_valid,
  output logic [DATA_W-1:0]  b_data,
  output logic [DATA_W-1:0]  b_bin,
  output logic               b_err,
  output logic [COUNT_W-1:0] b_count
);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DECODE,
    ACK
  } state_t;

  state_t               r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                 r_req_prev;
  logic [DATA_W-1:0]    r_data_q;
  logic                 r_ack;
  logic                 r_valid;
  logic [DATA_W-1:0]    r_data;
  logic [DATA_W-1:0]    r_bin;
  logic [COUNT_W-1:0]   r_count;
  logic                 w_req_s;
  logic                 w_req_new;
  logic [DATA_W-1:0]    w_bin;

  assign w_req_s   = r_sync[SYNC_STAGES-1];
  assign w_req_new = (w_req_s != r_req_prev);

  always_comb begin
    w_bin = '0;
    w_bin[DATA_W-1] = r_data_q[DATA_W-1];
    for (int i = DATA_W - 2; i >= 0; i--) begin
      w_bin[i] = w_bin[i+1] ^ r_data_q[i];
    end
  end

`ifdef GRAY_CDC_STEP_CHECK_EN
  logic [DATA_W-1:0] r_last_q;
  logic              r_first;
  logic              r_err;
  logic [DATA_W-1:0] w_diff;
  logic              w_step_bad;

  // Exactly one differing bit: nonzero and a power of two.
  assign w_diff     = r_data_q ^ r_last_q;
  assign w_step_bad = (w_diff == '0) ||
                      ((w_diff & (w_diff - DATA_W'(1))) != '0);
  assign b_err      = r_err;
`else
  assign b_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync     <= '0;
      r_req_prev <= 1'b0;
      r_state    <= IDLE;
      r_data_q   <= '0;
      r_ack      <= 1'b0;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_bin      <= '0;
      r_count    <= '0;
`ifdef GRAY_CDC_STEP_CHECK_EN
      r_last_q   <= '0;
      r_first    <= 1'b1;
      r_err      <= 1'b0;
`endif
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], a_req};
      r_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_req_new) begin
            r_req_prev <= w_req_s;
            r_state    <= CAPTURE;
          end
        end
        CAPTURE: begin
          r_data_q <= a_data;
          r_state  <= DECODE;
        end
        DECODE: begin
          r_data  <= r_data_q;
          r_bin   <= w_bin;
          r_valid <= 1'b1;
          r_count <= r_count + COUNT_W'(1);
`ifdef GRAY_CDC_STEP_CHECK_EN
          r_err    <= r_first ? 1'b0 : w_step_bad;
          r_first  <= 1'b0;
          r_last_q <= r_data_q;
`endif
          r_state <= ACK;
        end
        ACK: begin
          r_ack   <= ~r_ack;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign b_ack   = r_ack;
  assign b_valid = r_valid;
  assign b_data  = r_data;
  assign b_bin   = r_bin;
  assign b_count = r_count;

endmodule
